// File: rtl/prog_mem_pkg.sv
// Shared types and defaults for the program-memory controller.
// Optional second read port: PROG_MEM_DUAL_FETCH_EN.
package prog_mem_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 2048;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    LOAD  = 2'd2
  } state_e;

endpackage

// File: rtl/prog_mem_array.sv
// Synchronous RAM: one write port, one (or two with
// PROG_MEM_DUAL_FETCH_EN) registered read ports, no reset.
module prog_mem_array
  import prog_mem_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
`ifdef PROG_MEM_DUAL_FETCH_EN
  input  logic [ADDR_W-1:0] raddr_hi,
  output logic [DATA_W-1:0] rdata_hi,
`endif
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
`ifdef PROG_MEM_DUAL_FETCH_EN
  logic [DATA_W-1:0] rdata_hi_q;
`endif

  // Read registers only load on a read, so they hold otherwise.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[raddr];
`ifdef PROG_MEM_DUAL_FETCH_EN
      rdata_hi_q <= mem_q[raddr_hi];
`endif
    end
  end

  assign rdata = rdata_q;
`ifdef PROG_MEM_DUAL_FETCH_EN
  assign rdata_hi = rdata_hi_q;
`endif

endmodule

// File: rtl/prog_mem_ctrl.sv
// Program-memory controller: fetch port, debug burst loader, mode FSM.
// Define PROG_MEM_DUAL_FETCH_EN to add the Fetch_data_hi read port.
module prog_mem_ctrl
  import prog_mem_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
`ifdef PROG_MEM_DUAL_FETCH_EN
  output logic [DATA_W-1:0] fetch_data_hi,
`endif
  input  logic              dbg_mode,
  output logic              dbg_busy,
  input  logic              dbg_addr_load,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic              dbg_wr_valid,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_wr_ready,
  output logic [ADDR_W-1:0] dbg_ptr,
  output logic              dbg_wrap
);

  state_e            state_q, state_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic              seen_q, seen_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              wrap_q, wrap_d;

  logic              fetch_acc;
  logic              wr_en;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] rdata;
  logic              unused_addr_hi;

  assign raddr          = fetch_addr[ADDR_W-1:0];
  assign unused_addr_hi = ^fetch_addr[31:ADDR_W];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (dbg_mode) state_d = FLUSH;
      FLUSH:   state_d = dbg_mode ? LOAD : RUN;
      LOAD:    if (!dbg_mode) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // ready_q is only ever high while the FSM sits in RUN.
  always_comb begin
    fetch_acc = fetch_req & ready_q;
    wr_en     = (state_q == LOAD) & dbg_wr_valid;
    target    = dbg_addr_load ? dbg_addr : ptr_q;
    ready_d   = (state_d == RUN);
    valid_d   = fetch_acc;
    seen_d    = seen_q | fetch_acc;
    ptr_d     = ptr_q;
    wrap_d    = 1'b0;
    if (wr_en) begin
      ptr_d  = target + ADDR_W'(1);
      wrap_d = (target == ADDR_W'(DEPTH - 1));
    end else if (dbg_addr_load) begin
      ptr_d = dbg_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      seen_q  <= 1'b0;
      ptr_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      seen_q  <= seen_d;
      ptr_q   <= ptr_d;
      wrap_q  <= wrap_d;
    end
  end

`ifdef PROG_MEM_DUAL_FETCH_EN
  logic [ADDR_W-1:0] raddr_hi;
  logic [DATA_W-1:0] rdata_hi;

  assign raddr_hi = raddr + ADDR_W'(1);
`endif

  prog_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk      (clk),
    .we       (wr_en),
    .waddr    (target),
    .wdata    (dbg_wdata),
    .re       (fetch_acc),
    .raddr    (raddr),
`ifdef PROG_MEM_DUAL_FETCH_EN
    .raddr_hi (raddr_hi),
    .rdata_hi (rdata_hi),
`endif
    .rdata    (rdata)
  );

  // The array has no reset; mask it until the first fetch lands.
  assign fetch_data = seen_q ? rdata : '0;
`ifdef PROG_MEM_DUAL_FETCH_EN
  assign fetch_data_hi = seen_q ? rdata_hi : '0;
`endif

  assign fetch_ready  = ready_q;
  assign fetch_valid  = valid_q;
  assign dbg_busy     = (state_q == LOAD);
  assign dbg_wr_ready = (state_q == LOAD);
  assign dbg_ptr      = ptr_q;
  assign dbg_wrap     = wrap_q;

endmodule

// File: tb/tb_prog_mem_ctrl.sv
// Scoreboard bench for prog_mem_ctrl (DEPTH=2048), optionally
// with PROG_MEM_DUAL_FETCH_EN.
module tb_prog_mem_ctrl;

  localparam int DW = 32;
  localparam int DP = 2048;
  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fetch_req;
  logic [31:0]   fetch_addr;
  logic          fetch_ready;
  logic          fetch_valid;
  logic [DW-1:0] fetch_data;
`ifdef PROG_MEM_DUAL_FETCH_EN
  logic [DW-1:0] fetch_data_hi;
`endif
  logic          dbg_mode;
  logic          dbg_busy;
  logic          dbg_addr_load;
  logic [AW-1:0] dbg_addr;
  logic          dbg_wr_valid;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_wr_ready;
  logic [AW-1:0] dbg_ptr;
  logic          dbg_wrap;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    bit          hchk;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model[int];
  int          tptr;
  int          checks;
  int          errors;

  always #5 clk = ~clk;

  prog_mem_ctrl #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_req     (fetch_req),
    .fetch_addr    (fetch_addr),
    .fetch_ready   (fetch_ready),
    .fetch_valid   (fetch_valid),
    .fetch_data    (fetch_data),
`ifdef PROG_MEM_DUAL_FETCH_EN
    .fetch_data_hi (fetch_data_hi),
`endif
    .dbg_mode      (dbg_mode),
    .dbg_busy      (dbg_busy),
    .dbg_addr_load (dbg_addr_load),
    .dbg_addr      (dbg_addr),
    .dbg_wr_valid  (dbg_wr_valid),
    .dbg_wdata     (dbg_wdata),
    .dbg_wr_ready  (dbg_wr_ready),
    .dbg_ptr       (dbg_ptr),
    .dbg_wrap      (dbg_wrap)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%h want=%h", n, act, req);
    end
  endtask

  task automatic dwr(input logic ld, input int a,
                     input logic [31:0] d);
    dbg_addr_load = ld;
    dbg_addr      = AW'(a);
    dbg_wr_valid  = 1'b1;
    dbg_wdata     = d;
    if (ld) tptr = a;
    model[tptr] = d;
    tptr = (tptr + 1) % DP;
    tick();
    dbg_addr_load = 1'b0;
    dbg_wr_valid  = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int   h;
    h      = (int'(a[AW-1:0]) + 1) % DP;
    e.lo   = d;
    e.hchk = model.exists(h);
    e.hi   = e.hchk ? model[h] : 32'h0;
    exp_q.push_back(e);
    fetch_req  = 1'b1;
    fetch_addr = a;
    tick();
    fetch_req  = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    tptr   = 0;
    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (fetch_valid === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid data=%h want=no_valid",
                     fetch_data);
          end else begin
            e = exp_q.pop_front();
            chk("fetch_data", fetch_data, e.lo);
`ifdef PROG_MEM_DUAL_FETCH_EN
            if (e.hchk) chk("fetch_data_hi", fetch_data_hi, e.hi);
`endif
          end
        end
      end
    join_none

    rst_n         = 1'b0;
    fetch_req     = 1'b0;
    fetch_addr    = '0;
    dbg_mode      = 1'b0;
    dbg_addr_load = 1'b0;
    dbg_addr      = '0;
    dbg_wr_valid  = 1'b0;
    dbg_wdata     = '0;
    repeat (2) tick();
    chk("rst_ready", 32'(fetch_ready), 0);
    chk("rst_valid", 32'(fetch_valid), 0);
    chk("rst_data", fetch_data, 0);
`ifdef PROG_MEM_DUAL_FETCH_EN
    chk("rst_data_hi", fetch_data_hi, 0);
`endif
    chk("rst_busy", 32'(dbg_busy), 0);
    chk("rst_wr_ready", 32'(dbg_wr_ready), 0);
    chk("rst_ptr", 32'(dbg_ptr), 0);
    chk("rst_wrap", 32'(dbg_wrap), 0);
    rst_n = 1'b1;
    #1;
    chk("ready_pre_edge", 32'(fetch_ready), 0);
    tick();
    chk("ready_first_edge", 32'(fetch_ready), 1);

    // Enter LOAD and burst four words from address 0.
    dbg_mode = 1'b1;
    tick();
    chk("flush_ready", 32'(fetch_ready), 0);
    chk("flush_busy", 32'(dbg_busy), 0);
    tick();
    chk("load_busy", 32'(dbg_busy), 1);
    chk("load_wr_ready", 32'(dbg_wr_ready), 1);
    dwr(1'b1, 0, 32'h11);
    dwr(1'b0, 0, 32'h22);
    dwr(1'b0, 0, 32'h33);
    dwr(1'b0, 0, 32'h44);
    chk("burst_ptr", 32'(dbg_ptr), 4);
    dbg_mode = 1'b0;
    tick();
    chk("run_ready", 32'(fetch_ready), 1);
    chk("run_busy", 32'(dbg_busy), 0);
    fetch(32'd2, 32'h33);
    fetch(32'd0, 32'h11);
    fetch(32'd1, 32'h22);
    fetch(32'd3, 32'h44);
    tick();

    // Fetch in the cycle Dbg_mode rises drains during FLUSH.
    dbg_mode = 1'b1;
    fetch(32'd1, 32'h22);
    chk("drain_ready", 32'(fetch_ready), 0);
    chk("drain_busy", 32'(dbg_busy), 0);
    tick();
    chk("drain_busy2", 32'(dbg_busy), 1);
    fetch_req  = 1'b1;
    fetch_addr = 32'd0;
    repeat (2) tick();
    fetch_req = 1'b0;

    // Pointer wrap at DEPTH-1.
    dwr(1'b1, DP - 1, 32'hAA);
    chk("wrap_pulse", 32'(dbg_wrap), 1);
    chk("wrap_ptr", 32'(dbg_ptr), 0);
    dwr(1'b0, 0, 32'hBB);
    chk("wrap_once", 32'(dbg_wrap), 0);
    chk("wrap_ptr2", 32'(dbg_ptr), 1);

    // Write coinciding with Dbg_mode falling.
    dbg_mode = 1'b0;
    dwr(1'b1, 5, 32'h66);
    chk("exit_ptr", 32'(dbg_ptr), 6);
    chk("exit_busy", 32'(dbg_busy), 0);
    chk("exit_ready", 32'(fetch_ready), 1);
    fetch(32'd2047, 32'hAA);
    fetch(32'd0, 32'hBB);
    fetch(32'hFFFF_F803, 32'h44);
    fetch(32'd5, 32'h66);
    repeat (2) tick();

    // Reset in the middle of a burst.
    dbg_mode = 1'b1;
    repeat (2) tick();
    dwr(1'b1, 7, 32'h55);
    chk("mid_ptr", 32'(dbg_ptr), 8);
    dbg_addr_load = 1'b1;
    dbg_addr      = AW'(7);
    dbg_wr_valid  = 1'b1;
    dbg_wdata     = 32'h99;
    rst_n         = 1'b0;
    #1;
    chk("mid_rst_ptr", 32'(dbg_ptr), 0);
    chk("mid_rst_busy", 32'(dbg_busy), 0);
    chk("mid_rst_ready", 32'(fetch_ready), 0);
    tick();
    dbg_addr_load = 1'b0;
    dbg_wr_valid  = 1'b0;
    dbg_mode      = 1'b0;
    rst_n         = 1'b1;
    tick();
    chk("post_rst_ready", 32'(fetch_ready), 1);
    fetch(32'd7, 32'h55);
    repeat (3) tick();
    chk("sb_drain", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
